// File: rtl/hamming_sched.sv
// hamming_sched
//   Round-robin scheduler that shares one Hamming(7,4) decode/correct core
//   between NREQ requesters. Each transaction goes through IDLE (grant and
//   capture), DEC (correct and register) and RESP (hold the response until it
//   is accepted), so the fastest rate is one transaction every 3 cycles.
//
// Parameters
//   NREQ   number of requesters, 2..4
//   CNT_W  width of the corrected-error counter
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; overrides every other event
//   req        req[k]=1: requester k presents a codeword on cw[7k+6:7k]
//   cw         codewords; bit i of each slice is Hamming position i+1
//   gnt        one-hot pulse: that requester's codeword is captured this edge
//   rsp_valid  response valid (RESP state)
//   rsp_ready  consumer accepts the response
//   rsp_id     requester index of the response
//   rsp_data   corrected data {d3,d2,d1,d0}
//   rsp_syn    syndrome {s4,s2,s1}; nonzero = corrected bit position
//   rsp_err    syndrome != 0
//   busy       FSM not in IDLE
//   corr_cnt   saturating count of accepted responses with rsp_err=1
//
// Optional feature
//   HAM_STATS_EN: builds the corrected-error counter; when undefined the
//   counter is absent and corr_cnt is tied to zero.

module hamming_sched #(
  parameter int NREQ  = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [7*NREQ-1:0]    cw,
  output logic [NREQ-1:0]      gnt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [3:0]           rsp_data,
  output logic [2:0]           rsp_syn,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     corr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DEC, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] rr_q, rr_d;
  logic [6:0] cap_cw_q, cap_cw_d;
  logic [1:0] cap_id_q, cap_id_d;
  logic [1:0] id_q, id_d;
  logic [3:0] data_q, data_d;
  logic [2:0] syn_q, syn_d;
  logic       err_q, err_d;

  // Arbiter: search from rr_q upward with wrap; req is widened to 4 bits so
  // the search index can always be 2 bits wide.
  logic [3:0] req4;
  logic [2:0] sum;
  logic       found;
  logic [1:0] win;
  logic [6:0] win_cw;

  always_comb begin
    req4           = '0;
    req4[NREQ-1:0] = req;
    sum            = '0;
    found          = 1'b0;
    win            = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_q} + 3'(i);
      if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
      if (!found && req4[sum[1:0]]) begin
        found = 1'b1;
        win   = sum[1:0];
      end
    end
    win_cw = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win == 2'(k)) win_cw = cw[7*k +: 7];
    end
  end

  // Decoder: syndrome names the erroneous position; flip it, then extract data.
  logic [2:0] dec_syn;
  logic [6:0] dec_fix;

  always_comb begin
    dec_syn[0] = cap_cw_q[0] ^ cap_cw_q[2] ^ cap_cw_q[4] ^ cap_cw_q[6];
    dec_syn[1] = cap_cw_q[1] ^ cap_cw_q[2] ^ cap_cw_q[5] ^ cap_cw_q[6];
    dec_syn[2] = cap_cw_q[3] ^ cap_cw_q[4] ^ cap_cw_q[5] ^ cap_cw_q[6];
    dec_fix    = cap_cw_q;
    if (dec_syn != 3'd0) dec_fix = cap_cw_q ^ (7'd1 << (dec_syn - 3'd1));
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cap_cw_d = cap_cw_q;
    cap_id_d = cap_id_q;
    id_d     = id_q;
    data_d   = data_q;
    syn_d    = syn_q;
    err_d    = err_q;
    gnt      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found && !rst) begin
          gnt      = NREQ'(1) << win;
          cap_cw_d = win_cw;
          cap_id_d = win;
          rr_d     = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
          state_d  = S_DEC;
        end
      end
      S_DEC: begin
        id_d    = cap_id_q;
        data_d  = {dec_fix[6], dec_fix[5], dec_fix[4], dec_fix[2]};
        syn_d   = dec_syn;
        err_d   = (dec_syn != 3'd0);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      cap_cw_q <= '0;
      cap_id_q <= '0;
      id_q     <= '0;
      data_q   <= '0;
      syn_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cap_cw_q <= cap_cw_d;
      cap_id_q <= cap_id_d;
      id_q     <= id_d;
      data_q   <= data_d;
      syn_q    <= syn_d;
      err_q    <= err_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_syn   = syn_q;
  assign rsp_err   = err_q;

`ifdef HAM_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_RESP) && rsp_ready && err_q && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign corr_cnt = cnt_q;
`else
  assign corr_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_sched.sv
module tb_hamming_sched;

  localparam int NREQ  = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [7*NREQ-1:0] cw;
  logic [NREQ-1:0]  gnt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [3:0]       rsp_data;
  logic [2:0]       rsp_syn;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] corr_cnt;

  hamming_sched #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .cw(cw), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_syn(rsp_syn), .rsp_err(rsp_err),
    .busy(busy), .corr_cnt(corr_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_cnt = 0;
  int unsigned last_g  = NREQ - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: the syndrome is the XOR of the positions of all set bits.
  function automatic logic [6:0] ref_decode(input logic [6:0] c);
    int unsigned s;
    logic [6:0]  f;
    s = 0;
    for (int p = 1; p <= 7; p++) if (c[p-1]) s = s ^ p;
    f = c;
    if (s != 0) f[s-1] = ~f[s-1];
    return {f[6], f[5], f[4], f[2], 3'(s)};
  endfunction

  function automatic int unsigned rr_pick(input logic [NREQ-1:0] m, input int unsigned last);
    for (int unsigned i = 1; i <= NREQ; i++)
      if (m[(last + i) % NREQ]) return (last + i) % NREQ;
    return 0;
  endfunction

  function automatic int unsigned cnt_after(input int unsigned c, input logic e);
`ifdef HAM_STATS_EN
    if (e && c < (1 << CNT_W) - 1) return c + 1;
    return c;
`else
    return 0;
`endif
  endfunction

  // One transaction starting in an IDLE cycle just after a rising edge.
  task automatic run_txn(input logic [1:0] rq, input logic [6:0] c0, input logic [6:0] c1,
                         input int unsigned stall, input logic [1:0] eg, input logic [1:0] eid,
                         input logic [3:0] ed, input logic [2:0] es, input logic ee,
                         input string tag);
    req = rq; cw = {c1, c0}; rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".idle_busy"}, 32'(busy), 0);
    @(posedge clk); #1;
    req = rq & ~eg;
    @(negedge clk);
    chk({tag, ".dec_gnt"}, 32'(gnt), 0);
    chk({tag, ".dec_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".dec_busy"}, 32'(busy), 1);
    @(posedge clk); #1;
    rsp_ready = (stall == 0);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(rsp_valid), 1);
    chk({tag, ".rsp"}, {rsp_id, rsp_data, rsp_syn, rsp_err}, {eid, ed, es, ee});
    for (int unsigned j = 0; j < stall; j++) begin
      @(posedge clk); #1;
      rsp_ready = (j == stall - 1);
      @(negedge clk);
      chk({tag, ".stall_valid"}, 32'(rsp_valid), 1);
      chk({tag, ".stall_rsp"}, {rsp_id, rsp_data, rsp_syn, rsp_err}, {eid, ed, es, ee});
      chk({tag, ".stall_gnt"}, 32'(gnt), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt = cnt_after(exp_cnt, ee);
    chk({tag, ".post_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".post_busy"}, 32'(busy), 0);
    chk({tag, ".corr_cnt"}, 32'(corr_cnt), exp_cnt);
  endtask

  typedef struct {
    logic [1:0]  rq;
    logic [6:0]  c0, c1;
    int unsigned stall;
    logic [1:0]  eg, eid;
    logic [3:0]  ed;
    logic [2:0]  es;
    logic        ee;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b01, 7'h55, 7'h00, 0, 2'b01, 2'd0, 4'hB, 3'd0, 1'b0};
    vecs[1] = '{2'b01, 7'h45, 7'h00, 0, 2'b01, 2'd0, 4'hB, 3'd5, 1'b1};
    vecs[2] = '{2'b11, 7'h55, 7'h07, 0, 2'b10, 2'd1, 4'h1, 3'd0, 1'b0};
    vecs[3] = '{2'b11, 7'h55, 7'h06, 5, 2'b01, 2'd0, 4'hB, 3'd0, 1'b0};
    vecs[4] = '{2'b10, 7'h55, 7'h06, 0, 2'b10, 2'd1, 4'h1, 3'd1, 1'b1};
    vecs[5] = '{2'b01, 7'h40, 7'h00, 1, 2'b01, 2'd0, 4'h0, 3'd7, 1'b1};
    vecs[6] = '{2'b10, 7'h00, 7'h7F, 0, 2'b10, 2'd1, 4'hF, 3'd0, 1'b0};
    vecs[7] = '{2'b01, 7'h56, 7'h00, 2, 2'b01, 2'd0, 4'hA, 3'd3, 1'b1};

    rst = 1'b1; req = '0; cw = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    req = 2'b11;
    @(negedge clk);
    chk("reset.outputs", {30'(gnt), rsp_valid, busy}, 0);
    chk("reset.rsp", {rsp_id, rsp_data, rsp_syn, rsp_err}, 0);
    chk("reset.corr_cnt", 32'(corr_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0; req = '0;

    foreach (vecs[i])
      run_txn(vecs[i].rq, vecs[i].c0, vecs[i].c1, vecs[i].stall, vecs[i].eg, vecs[i].eid,
              vecs[i].ed, vecs[i].es, vecs[i].ee, $sformatf("vec%0d", i));

    // Held requests alternate at 3-cycle spacing.
    req = 2'b11; cw = {7'h07, 7'h55}; rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("hold.gnt", 32'(gnt), (n % 2 == 0) ? 32'd2 : 32'd1);
      repeat (2) begin
        @(negedge clk);
        chk("hold.gap", 32'(gnt), 0);
      end
    end
    @(posedge clk); #1;
    req = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;

    // Reset during DEC drops the in-flight codeword.
    req = 2'b01; cw = {7'h00, 7'h45};
    @(negedge clk);
    chk("rstdec.gnt", 32'(gnt), 1);
    @(posedge clk); #1;
    req = '0; rst = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rstdec.state", {30'(gnt), rsp_valid, busy}, 0);
    chk("rstdec.rsp", {rsp_id, rsp_data, rsp_syn, rsp_err}, 0);
    chk("rstdec.corr_cnt", 32'(corr_cnt), 0);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("rstdec.no_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt = 0;
    last_g = NREQ - 1;

    // Randomized traffic against the reference model.
    begin
      logic [NREQ-1:0] pend;
      logic [6:0]      cws[NREQ];
      int unsigned     w;
      logic [6:0]      r;
      pend = '0;
      foreach (cws[k]) cws[k] = '0;
      for (int t = 0; t < 60; t++) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!pend[k] && $urandom_range(1, 0) == 1) begin
            pend[k] = 1'b1;
            cws[k]  = 7'($urandom);
          end
        end
        if (pend == '0) begin
          pend[0] = 1'b1;
          cws[0]  = 7'($urandom);
        end
        w = rr_pick(pend, last_g);
        r = ref_decode(cws[w]);
        run_txn(pend, cws[0], cws[1], $urandom_range(3, 0), 2'(1 << w), 2'(w),
                r[6:3], r[2:0], r[2:0] != 3'd0, "rand");
        pend[w] = 1'b0;
        last_g = w;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
